// File: rtl/instr_fetch_stage.sv
// Fetch stage: reads pc_in from instruction memory over req/ack and fills the IF/ID register.
// Zero-wait memory gives one instruction per 2 cycles; a stalled return parks in a one-word skid (HOLD), flush kills in-flight fetches.
module instr_fetch_stage #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h0000_0013)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush_in,
    input  logic              stall_in,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              pc_advance,
    output logic              ifid_valid,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [ADDR_W-1:0] ifid_pc_plus4,
    output logic [DATA_W-1:0] ifid_instr
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] skid_dat;
    logic              slot_free;
    logic              ack_live;
    logic              issue;
    logic              load_mem;
    logic              load_skid;
    logic              park;
    logic              req_done;

    assign slot_free = !ifid_valid || !stall_in;
    assign ack_live  = imem_ack && imem_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!flush_in) state_nxt = REQ;
            REQ: begin
                if (ack_live) begin
                    state_nxt = (flush_in || slot_free) ? IDLE : HOLD;
                end else if (flush_in) begin
                    state_nxt = DRAIN;
                end
            end
            HOLD:  if (flush_in || slot_free) state_nxt = IDLE;
            DRAIN: if (ack_live) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // pc_advance is combinational so the PC stage has the next PC ready when IDLE samples pc_in.
    always_comb begin
        issue     = 1'b0;
        load_mem  = 1'b0;
        load_skid = 1'b0;
        park      = 1'b0;
        req_done  = 1'b0;
        case (state)
            IDLE:  issue = !flush_in;
            REQ: begin
                load_mem = ack_live && !flush_in && slot_free;
                park     = ack_live && !flush_in && !slot_free;
                req_done = ack_live;
            end
            HOLD:  load_skid = !flush_in && slot_free;
            DRAIN: req_done = ack_live;
            default: ;
        endcase
        pc_advance = rst && (flush_in || load_mem || load_skid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_req      <= 1'b0;
            imem_addr     <= '0;
            skid_dat      <= '0;
            ifid_valid    <= 1'b0;
            ifid_pc       <= '0;
            ifid_pc_plus4 <= '0;
            ifid_instr    <= NOP_INSTR;
        end else begin
            if (issue) begin
                imem_req  <= 1'b1;
                imem_addr <= pc_in;
            end else if (req_done) begin
                imem_req  <= 1'b0;
            end

            if (park) begin
                skid_dat <= imem_rdata;
            end

            // imem_addr still holds the fetched address in both REQ and HOLD.
            if (flush_in) begin
                ifid_valid <= 1'b0;
                ifid_instr <= NOP_INSTR;
            end else if (load_mem || load_skid) begin
                ifid_valid    <= 1'b1;
                ifid_pc       <= imem_addr;
                ifid_pc_plus4 <= imem_addr + ADDR_W'(4);
                ifid_instr    <= load_mem ? imem_rdata : skid_dat;
            end else if (!stall_in) begin
                ifid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios pinned with literals, then randomized traffic vs a transaction-level model.
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc_in = '0;
    logic        flush_in = 1'b0;
    logic        stall_in = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        pc_advance;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_instr;

    instr_fetch_stage #(.ADDR_W(32), .DATA_W(32), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .flush_in(flush_in), .stall_in(stall_in),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc_advance(pc_advance), .ifid_valid(ifid_valid), .ifid_pc(ifid_pc),
        .ifid_pc_plus4(ifid_pc_plus4), .ifid_instr(ifid_instr)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          adv_cnt = 0;
    int          force_lat = -1;
    int          lat_cnt = 0;
    logic        use_word = 1'b0;
    logic        spurious = 1'b0;
    logic [31:0] ack_word = '0;

    // Model: an outstanding fetch (possibly doomed by a flush), a parked word, the IF/ID entry and the PC stage.
    logic        m_req, m_doomed, m_valid;
    logic [31:0] m_addr, m_pc, m_p4, m_instr, pc_reg;
    logic [31:0] parked[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_req = 1'b0; m_doomed = 1'b0; m_valid = 1'b0;
        m_addr = '0; m_pc = '0; m_p4 = '0; m_instr = NOP;
        pc_reg = '0; lat_cnt = 0;
        parked.delete();
    endtask

    // Entered just after a falling edge; returns at the next falling edge.
    task automatic step(input logic f, input logic s, input logic [31:0] tgt);
        logic        ack, free, got, acc_mem, acc_park, adv, idle;
        logic [31:0] rd, pcn;
        pcn = pc_reg;
        ack = 1'b0;
        rd  = $urandom;
        if (m_req) begin
            if (lat_cnt == 0) begin
                ack = 1'b1;
                if (use_word) rd = ack_word;
            end else begin
                lat_cnt--;
            end
        end else if (spurious && $urandom_range(0, 3) == 0) begin
            ack = 1'b1;
        end
        flush_in = f; stall_in = s; pc_in = pcn; imem_ack = ack; imem_rdata = rd;

        free     = !m_valid || !s;
        got      = m_req && ack;
        acc_mem  = got && !m_doomed && !f && free;
        acc_park = (parked.size() != 0) && !f && free;
        adv      = f || acc_mem || acc_park;

        #1;
        chk("imem_req", imem_req, m_req);
        chk("imem_addr", imem_addr, m_addr);
        chk("ifid_valid", ifid_valid, m_valid);
        chk("ifid_pc", ifid_pc, m_pc);
        chk("ifid_pc_plus4", ifid_pc_plus4, m_p4);
        chk("ifid_instr", ifid_instr, m_instr);
        chk("pc_advance", pc_advance, adv);
        if (pc_advance) adv_cnt++;

        @(posedge clk);
        idle = !m_req && (parked.size() == 0);
        if (f) begin
            m_valid = 1'b0; m_instr = NOP;
        end else if (acc_mem || acc_park) begin
            m_valid = 1'b1; m_pc = m_addr; m_p4 = m_addr + 32'd4;
            m_instr = acc_mem ? rd : parked.pop_front();
        end else if (!s) begin
            m_valid = 1'b0;
        end
        if (got && !m_doomed && !f && !free) parked.push_back(rd);
        if (f) parked.delete();
        if (got) begin
            m_req = 1'b0; m_doomed = 1'b0;
        end else if (m_req && f) begin
            m_doomed = 1'b1;
        end
        if (idle && !f) begin
            m_req = 1'b1; m_addr = pcn;
            lat_cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
        end
        if (adv) pc_reg = f ? tgt : pc_reg + 32'd4;
        @(negedge clk);
    endtask

    // Reset asserted between edges, with flush_in high to show pc_advance is forced low.
    task automatic mid_reset();
        flush_in = 1'b1; imem_ack = 1'b0; stall_in = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_req", imem_req, 0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_adv", pc_advance, 0);
        chk("rst_valid", ifid_valid, 0);
        chk("rst_pc", ifid_pc, 0);
        chk("rst_p4", ifid_pc_plus4, 0);
        chk("rst_instr", ifid_instr, NOP);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        mid_reset();

        // Zero-wait fetch of 0,4,8
        force_lat = 0; adv_cnt = 0;
        step(0, 0, 0); step(0, 0, 0);
        chk("t1_pc0", ifid_pc, 32'h0); chk("t1_p4_0", ifid_pc_plus4, 32'h4);
        step(0, 0, 0); step(0, 0, 0);
        chk("t1_pc1", ifid_pc, 32'h4); chk("t1_p4_1", ifid_pc_plus4, 32'h8);
        step(0, 0, 0); step(0, 0, 0);
        chk("t1_pc2", ifid_pc, 32'h8); chk("t1_p4_2", ifid_pc_plus4, 32'hC);
        chk("t1_adv", adv_cnt, 3);

        // Flush to 0x20, then a 3-cycle-late ack
        step(1, 0, 32'h20);
        chk("t2_flush_valid", ifid_valid, 0); chk("t2_flush_instr", ifid_instr, NOP);
        force_lat = 3; use_word = 1'b1; ack_word = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0);
            chk("t2_req_held", imem_req, 1); chk("t2_addr_held", imem_addr, 32'h20);
        end
        step(0, 0, 0);
        chk("t2_valid", ifid_valid, 1); chk("t2_pc", ifid_pc, 32'h20);
        chk("t2_instr", ifid_instr, 32'h1234_5678); chk("t2_req_off", imem_req, 0);

        // Return under stall parks, release loads it
        force_lat = 0; ack_word = 32'hDEAD_BEEF;
        step(0, 1, 0);
        chk("t3_addr", imem_addr, 32'h24);
        adv_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            chk("t3_held_pc", ifid_pc, 32'h20); chk("t3_held_instr", ifid_instr, 32'h1234_5678);
            chk("t3_no_req", imem_req, 0);
        end
        chk("t3_no_adv", adv_cnt, 0);
        step(0, 0, 0);
        chk("t3_instr", ifid_instr, 32'hDEAD_BEEF); chk("t3_pc", ifid_pc, 32'h24);
        chk("t3_adv", adv_cnt, 1);

        // Flush before a late ack: word discarded, next fetch at 0x100
        force_lat = 3; ack_word = 32'hBADB_AD00;
        step(0, 0, 0);
        chk("t4_addr", imem_addr, 32'h28);
        step(1, 0, 32'h100);
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        chk("t4_valid", ifid_valid, 0); chk("t4_instr", ifid_instr, NOP);
        force_lat = 0;
        step(0, 0, 0);
        chk("t4_req", imem_req, 1); chk("t4_target", imem_addr, 32'h100);

        // Flush and ack together
        ack_word = 32'h0BAD_F00D; adv_cnt = 0;
        step(1, 0, 32'h200);
        chk("t5_adv", adv_cnt, 1); chk("t5_valid", ifid_valid, 0);
        chk("t5_instr", ifid_instr, NOP); chk("t5_idle", imem_req, 0);
        step(0, 0, 0);
        chk("t5_target", imem_addr, 32'h200);

        // Reset mid-request, then restart from 0
        mid_reset();
        step(0, 0, 0);
        chk("t6_req", imem_req, 1); chk("t6_addr", imem_addr, 32'h0);

        // Address wrap at the top of memory
        step(1, 0, 32'hFFFF_FFFC);
        step(0, 0, 0); step(0, 0, 0);
        chk("t7_pc", ifid_pc, 32'hFFFF_FFFC); chk("t7_p4_wrap", ifid_pc_plus4, 32'h0);

        // Randomized traffic
        force_lat = -1; use_word = 1'b0; spurious = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            if (i % 700 == 699) mid_reset();
            step($urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0, tgt);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
